// File: rtl/commit_trace_pkg.sv
// Shared widths and trace entry layout for the commit trace FIFO.
// COMMIT_TRACE_SEQ_EN adds a sequence number field to each entry.
package commit_trace_pkg;

   localparam int PC_W   = 64;
   localparam int REG_W  = 5;
   localparam int DATA_W = 64;
   localparam int SEQ_W  = 32;
   localparam int DROP_W = 16;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [REG_W-1:0]  reg_num;
      logic [DATA_W-1:0] wdata;
`ifdef COMMIT_TRACE_SEQ_EN
      logic [SEQ_W-1:0]  seq;
`endif
   } trace_entry_t;

endpackage

// File: rtl/commit_trace_ram.sv
// DEPTH-entry register array, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module commit_trace_ram
   import commit_trace_pkg::*;
#(
   parameter int DEPTH = 16
)
(
   input  logic                     clock,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  trace_entry_t             wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output trace_entry_t             rd_data
);

   trace_entry_t mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/commit_trace_fifo.sv
// First-word fall-through FIFO capturing retired-instruction commits for trace.
// Define COMMIT_TRACE_SEQ_EN to tag each entry with a 32-bit sequence number.
module commit_trace_fifo
   import commit_trace_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 14
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              debug_commit,
   input  logic [PC_W-1:0]   debug_pc,
   input  logic [REG_W-1:0]  debug_reg_num,
   input  logic [DATA_W-1:0] debug_wdata,
   output logic              trace_valid,
   input  logic              trace_ready,
   output logic [PC_W-1:0]   trace_pc,
   output logic [REG_W-1:0]  trace_reg_num,
   output logic [DATA_W-1:0] trace_wdata,
`ifdef COMMIT_TRACE_SEQ_EN
   output logic [SEQ_W-1:0]  trace_seq,
`endif
   output logic              trace_afull,
   output logic              trace_overflow,
   output logic [DROP_W-1:0] trace_drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   logic          drop;
   trace_entry_t  wr_entry;
   trace_entry_t  head;

`ifdef COMMIT_TRACE_SEQ_EN
   logic [SEQ_W-1:0] seq_cnt;
`endif

   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   always_comb begin
      pop  = trace_valid & trace_ready;
      push = debug_commit & ((count != CW'(DEPTH)) | pop);
      drop = debug_commit & ~push;
   end

   always_comb begin
      wr_entry         = '0;
      wr_entry.pc      = debug_pc;
      wr_entry.reg_num = debug_reg_num;
      wr_entry.wdata   = debug_wdata;
`ifdef COMMIT_TRACE_SEQ_EN
      wr_entry.seq     = seq_cnt;
`endif
   end

   commit_trace_ram #(.DEPTH(DEPTH)) u_ram (
      .clock   (clock),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr),
      .rd_data (head)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         trace_overflow <= 1'b0;
         trace_drop_cnt <= '0;
      end else if (drop) begin
         trace_overflow <= 1'b1;
         if (trace_drop_cnt != '1) trace_drop_cnt <= trace_drop_cnt + DROP_W'(1);
      end
   end

`ifdef COMMIT_TRACE_SEQ_EN
   // Dropped commits still consume a number so gaps expose lost entries.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         seq_cnt <= '0;
      end else if (debug_commit) begin
         seq_cnt <= seq_cnt + SEQ_W'(1);
      end
   end

   assign trace_seq = head.seq;
`endif

   assign trace_valid   = (count != '0);
   assign trace_afull   = (count >= CW'(AF_LEVEL));
   assign trace_pc      = head.pc;
   assign trace_reg_num = head.reg_num;
   assign trace_wdata   = head.wdata;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Scoreboard bench for commit_trace_fifo: directed stimulus queues expected
// entries, a negedge monitor pops and compares every accepted head entry.
module tb_commit_trace_fifo;
   import commit_trace_pkg::*;

   logic              clock = 1'b0;
   logic              reset;
   logic              debug_commit;
   logic [PC_W-1:0]   debug_pc;
   logic [REG_W-1:0]  debug_reg_num;
   logic [DATA_W-1:0] debug_wdata;
   logic              trace_valid;
   logic              trace_ready;
   logic [PC_W-1:0]   trace_pc;
   logic [REG_W-1:0]  trace_reg_num;
   logic [DATA_W-1:0] trace_wdata;
`ifdef COMMIT_TRACE_SEQ_EN
   logic [SEQ_W-1:0]  trace_seq;
`endif
   logic              trace_afull;
   logic              trace_overflow;
   logic [DROP_W-1:0] trace_drop_cnt;

   int errors = 0;
   int checks = 0;
   int n_pops = 0;
   int unsigned seq_model = 0;
   trace_entry_t sb [$];

   always #5 clock = ~clock;

   commit_trace_fifo #(.DEPTH(16), .AF_LEVEL(14)) dut (
      .clock          (clock),
      .reset          (reset),
      .debug_commit   (debug_commit),
      .debug_pc       (debug_pc),
      .debug_reg_num  (debug_reg_num),
      .debug_wdata    (debug_wdata),
      .trace_valid    (trace_valid),
      .trace_ready    (trace_ready),
      .trace_pc       (trace_pc),
      .trace_reg_num  (trace_reg_num),
      .trace_wdata    (trace_wdata),
`ifdef COMMIT_TRACE_SEQ_EN
      .trace_seq      (trace_seq),
`endif
      .trace_afull    (trace_afull),
      .trace_overflow (trace_overflow),
      .trace_drop_cnt (trace_drop_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every handshake must match the oldest expected entry.
   always @(negedge clock) begin
      if (!reset && trace_valid && trace_ready) begin
         if (sb.size() == 0) begin
            chk("spurious_valid", 64'(trace_valid), 64'd0);
         end else begin
            trace_entry_t e;
            e = sb.pop_front();
            chk("head_pc", trace_pc, e.pc);
            chk("head_reg", 64'(trace_reg_num), 64'(e.reg_num));
            chk("head_wdata", trace_wdata, e.wdata);
`ifdef COMMIT_TRACE_SEQ_EN
            chk("head_seq", 64'(trace_seq), 64'(e.seq));
`endif
         end
         n_pops++;
      end
   end

   task automatic commit(input logic [63:0] pc, input bit acc);
      trace_entry_t e;
      e = '0;
      e.pc      = pc;
      e.reg_num = pc[6:2];
      e.wdata   = ~pc ^ 64'h0000_1234_0000_0000;
`ifdef COMMIT_TRACE_SEQ_EN
      e.seq     = seq_model;
`endif
      seq_model++;
      debug_commit  = 1'b1;
      debug_pc      = e.pc;
      debug_reg_num = e.reg_num;
      debug_wdata   = e.wdata;
      if (acc) sb.push_back(e);
      @(posedge clock); #1;
   endtask

   task automatic idle(input int n);
      debug_commit = 1'b0;
      repeat (n) begin
         @(posedge clock); #1;
      end
   endtask

   initial begin
      int p0;
      reset = 1'b1;
      debug_commit = 1'b0;
      debug_pc = '0;
      debug_reg_num = '0;
      debug_wdata = '0;
      trace_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_valid", 64'(trace_valid), 64'd0);
      chk("rst_afull", 64'(trace_afull), 64'd0);
      chk("rst_overflow", 64'(trace_overflow), 64'd0);
      chk("rst_drop_cnt", 64'(trace_drop_cnt), 64'd0);
      reset = 1'b0;
      idle(1);

      // Three commits drain one per cycle starting the cycle after the first push.
      trace_ready = 1'b1;
      p0 = n_pops;
      commit(64'h8000_0000, 1);
      chk("lat_first", 64'(n_pops - p0), 64'd0);
      commit(64'h8000_0004, 1);
      chk("lat_second", 64'(n_pops - p0), 64'd1);
      commit(64'h8000_0008, 1);
      idle(1);
      chk("three_popped", 64'(n_pops - p0), 64'd3);
      chk("empty_after_three", 64'(trace_valid), 64'd0);

      // Fill to DEPTH with consumer stalled; afull threshold then a drop.
      trace_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         commit(64'h9000_0000 + 64'(4 * i), 1);
         if (i == 12) chk("afull_at_13", 64'(trace_afull), 64'd0);
         if (i == 13) chk("afull_at_14", 64'(trace_afull), 64'd1);
      end
      chk("full_no_overflow", 64'(trace_overflow), 64'd0);
      chk("full_afull", 64'(trace_afull), 64'd1);
      commit(64'h9000_0100, 0);
      chk("drop_overflow", 64'(trace_overflow), 64'd1);
      chk("drop_cnt_1", 64'(trace_drop_cnt), 64'd1);
      chk("drop_head_stable", trace_pc, 64'h9000_0000);

      // Push and pop together while full: accepted, FIFO stays full.
      trace_ready = 1'b1;
      commit(64'hA000_0000, 1);
      trace_ready = 1'b0;
      chk("fullpp_drop_cnt", 64'(trace_drop_cnt), 64'd1);
      chk("fullpp_head", trace_pc, 64'h9000_0004);
      commit(64'hA000_0004, 0);
      chk("still_full_drop", 64'(trace_drop_cnt), 64'd2);
      trace_ready = 1'b1;
      idle(18);
      chk("drain_sb_empty", 64'(sb.size()), 64'd0);
      chk("drain_valid", 64'(trace_valid), 64'd0);

      // Twenty streaming push/pop cycles wrap the pointers.
      p0 = n_pops;
      for (int i = 0; i < 20; i++) commit(64'hB000_0000 + 64'(4 * i), 1);
      idle(2);
      chk("stream_pops", 64'(n_pops - p0), 64'd20);
      chk("stream_sb_empty", 64'(sb.size()), 64'd0);
      chk("stream_valid", 64'(trace_valid), 64'd0);

      // Two dropped commits leave a gap of two in the sequence numbers.
      trace_ready = 1'b0;
      for (int i = 0; i < 16; i++) commit(64'hC000_0000 + 64'(4 * i), 1);
      commit(64'hC000_1000, 0);
      commit(64'hC000_1004, 0);
      chk("drop_cnt_4", 64'(trace_drop_cnt), 64'd4);
      trace_ready = 1'b1;
      commit(64'hC000_2000, 1);
      idle(18);
      chk("gap_sb_empty", 64'(sb.size()), 64'd0);

      // Reset with entries buffered clears everything at once.
      trace_ready = 1'b0;
      for (int i = 0; i < 5; i++) commit(64'hD000_0000 + 64'(4 * i), 1);
      chk("pre_rst_valid", 64'(trace_valid), 64'd1);
      chk("pre_rst_overflow", 64'(trace_overflow), 64'd1);
      debug_commit = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("async_rst_valid", 64'(trace_valid), 64'd0);
      chk("async_rst_afull", 64'(trace_afull), 64'd0);
      chk("async_rst_overflow", 64'(trace_overflow), 64'd0);
      chk("async_rst_drop_cnt", 64'(trace_drop_cnt), 64'd0);
      sb.delete();
      seq_model = 0;
      @(posedge clock); #1;
      reset = 1'b0;
      trace_ready = 1'b1;
      commit(64'hE000_0000, 1);
      idle(3);
      chk("post_rst_sb_empty", 64'(sb.size()), 64'd0);
      chk("post_rst_valid", 64'(trace_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
